// File: rtl/mtip_fe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mtip_fe_pkg
//  Description : Shared constants and types for the MTIP RX front end:
//                FC header word indices, frame-status bit positions, the
//                header-extract FSM encoding and the default frame limit.
//  Revision    : 1.0  initial release
// ============================================================================
package mtip_fe_pkg;

  // FC header word indices (word 0 is the first word of a frame)
  localparam int HDR_RCTL_DID  = 0;
  localparam int HDR_CSCTL_SID = 1;
  localparam int HDR_TYPE_FCTL = 2;
  localparam int HDR_SEQ       = 3;
  localparam int HDR_OXRX      = 4;
  localparam int HDR_PARAM     = 5;

  // Bit positions inside oFRM_STAT = {giant, trunc, runt, err}
  localparam int STAT_ERR   = 0;
  localparam int STAT_RUNT  = 1;
  localparam int STAT_TRUNC = 2;
  localparam int STAT_GIANT = 3;

  // Largest legal frame: 6 header words + 528 payload words
  localparam int DEFAULT_MAX_WORDS = 534;

  // Header-extract FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } hx_state_t;

endpackage : mtip_fe_pkg
`default_nettype wire

// File: rtl/mtip_sat_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : mtip_sat_cntr
//  Description : Saturating up-counter with synchronous clear. Clear takes
//                priority over a coincident increment; the count holds at
//                all-ones once reached.
//  Revision    : 1.0  initial release
// ============================================================================
module mtip_sat_cntr #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: clear first, then increment unless already saturated
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule : mtip_sat_cntr
`default_nettype wire

// File: rtl/mtip_hdr_extract.sv
`default_nettype none
// ============================================================================
//  Module      : mtip_hdr_extract
//  Description : Captures the FC header of each received frame, forwards the
//                payload with one cycle of registered latency, reports frame
//                length/status at frame close and keeps saturating frame,
//                error and orphan-word statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module mtip_hdr_extract
  import mtip_fe_pkg::*;
#(
  parameter int HDR_WORDS = 6,
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int LEN_W     = 12,
  parameter int CNT_W     = 32
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic [31:0]             iDATA,
  input  logic                    iSOP,
  input  logic                    iEOP,
  input  logic                    iERR,
  input  logic                    iDVAL,
  input  logic                    iCNT_CLR,
  output logic [HDR_WORDS*32-1:0] oHDR,
  output logic                    oHDR_VALID,
  output logic [31:0]             oPAY_DATA,
  output logic                    oPAY_VALID,
  output logic                    oPAY_SOP,
  output logic                    oPAY_EOP,
  output logic                    oFRM_DONE,
  output logic [LEN_W-1:0]        oFRM_LEN,
  output logic [3:0]              oFRM_STAT,
  output logic [CNT_W-1:0]        oFRM_CNT,
  output logic [CNT_W-1:0]        oERR_CNT,
  output logic [CNT_W-1:0]        oORPHAN_CNT
);

  localparam logic [LEN_W-1:0] LEN_HDR = LEN_W'(HDR_WORDS);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_WORDS + 1);

  hx_state_t               state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    pay_first_q, pay_first_d;  // next forwarded beat is the first
  logic                    giant_q, giant_d;          // words have been dropped this frame
  logic [HDR_WORDS*32-1:0] shadow_q, shadow_d;        // header under assembly
  logic [HDR_WORDS*32-1:0] hdr_q, hdr_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [31:0]             pay_data_q, pay_data_d;
  logic                    pay_valid_q, pay_valid_d;
  logic                    pay_sop_q, pay_sop_d;
  logic                    pay_eop_q, pay_eop_d;
  logic                    done_q, done_d;
  logic [LEN_W-1:0]        frm_len_q, frm_len_d;
  logic [3:0]              frm_stat_q, frm_stat_d;

  logic                    w_close;
  logic [3:0]              w_close_stat;
  logic                    w_start;
  logic                    w_orphan;
  logic [LEN_W-1:0]        w_len_inc;

  // Frame length increment, pinned at MAX_WORDS+1 once the frame is giant
  assign w_len_inc = (len_q >= LEN_SAT) ? LEN_SAT : (len_q + LEN_W'(1));

  // Next-state and output decode for the header/payload FSM
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pay_first_d  = pay_first_q;
    giant_d      = giant_q;
    shadow_d     = shadow_q;
    hdr_d        = hdr_q;
    hdr_valid_d  = 1'b0;
    pay_data_d   = '0;
    pay_valid_d  = 1'b0;
    pay_sop_d    = 1'b0;
    pay_eop_d    = 1'b0;
    done_d       = 1'b0;
    frm_len_d    = frm_len_q;
    frm_stat_d   = frm_stat_q;
    w_close      = 1'b0;
    w_close_stat = '0;
    w_start      = 1'b0;
    w_orphan     = 1'b0;

    if (iDVAL) begin
      case (state_q)
        ST_IDLE: begin
          if (iSOP) w_start  = 1'b1;
          else      w_orphan = 1'b1;
        end

        ST_HDR, ST_PAY: begin
          if (iSOP) begin
            // A new SOP truncates the open frame; the SOP word itself opens
            // the next frame in this same cycle.
            w_close                  = 1'b1;
            w_close_stat[STAT_TRUNC] = 1'b1;
            w_close_stat[STAT_GIANT] = giant_q;
            frm_len_d                = len_q;
            if (state_q == ST_PAY) begin
              pay_valid_d = 1'b1;
              pay_sop_d   = pay_first_q;
              pay_eop_d   = 1'b1;
            end
            w_start = 1'b1;
          end else if (state_q == ST_HDR) begin
            for (int i = 0; i < HDR_WORDS; i++) begin
              if (len_q == LEN_W'(i)) shadow_d[(HDR_WORDS-1-i)*32 +: 32] = iDATA;
            end
            len_d = len_q + LEN_W'(1);
            if (len_d == LEN_HDR) begin
              hdr_valid_d = 1'b1;
              hdr_d       = shadow_d;
              state_d     = ST_PAY;
            end
            if (iEOP) begin
              w_close                 = 1'b1;
              w_close_stat[STAT_ERR]  = iERR;
              w_close_stat[STAT_RUNT] = (len_d < LEN_HDR);
              frm_len_d               = len_d;
              state_d                 = ST_IDLE;
            end
          end else begin
            len_d = w_len_inc;
            if (len_q < LEN_MAX) begin
              pay_valid_d = 1'b1;
              pay_data_d  = iDATA;
              pay_sop_d   = pay_first_q;
              pay_eop_d   = iEOP;
              pay_first_d = 1'b0;
            end else begin
              giant_d = 1'b1;
            end
            if (iEOP) begin
              w_close                  = 1'b1;
              w_close_stat[STAT_ERR]   = iERR;
              w_close_stat[STAT_GIANT] = giant_d;
              frm_len_d                = len_d;
              state_d                  = ST_IDLE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase

      // Open a new frame with this word as header word 0. A SOP+EOP word is
      // a complete 1-word runt; if it also truncated an open frame, only the
      // truncated frame is reported.
      if (w_start) begin
        shadow_d[(HDR_WORDS-1-HDR_RCTL_DID)*32 +: 32] = iDATA;
        len_d       = LEN_W'(1);
        pay_first_d = 1'b1;
        giant_d     = 1'b0;
        state_d     = ST_HDR;
        if (iEOP) begin
          state_d = ST_IDLE;
          if (!w_close) begin
            w_close                 = 1'b1;
            w_close_stat[STAT_ERR]  = iERR;
            w_close_stat[STAT_RUNT] = 1'b1;
            frm_len_d               = LEN_W'(1);
          end
        end
      end
    end

    if (w_close) begin
      done_d     = 1'b1;
      frm_stat_d = w_close_stat;
    end
  end

  // State and output registers; reset discards any frame in progress
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      pay_first_q <= 1'b0;
      giant_q     <= 1'b0;
      shadow_q    <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_sop_q   <= 1'b0;
      pay_eop_q   <= 1'b0;
      done_q      <= 1'b0;
      frm_len_q   <= '0;
      frm_stat_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pay_first_q <= pay_first_d;
      giant_q     <= giant_d;
      shadow_q    <= shadow_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      pay_sop_q   <= pay_sop_d;
      pay_eop_q   <= pay_eop_d;
      done_q      <= done_d;
      frm_len_q   <= frm_len_d;
      frm_stat_q  <= frm_stat_d;
    end
  end

  mtip_sat_cntr #(.CNT_W(CNT_W)) u_frm_cntr (
    .clk_i (iCLK),
    .rst_i (iRESET),
    .inc_i (w_close),
    .clr_i (iCNT_CLR),
    .cnt_o (oFRM_CNT)
  );

  mtip_sat_cntr #(.CNT_W(CNT_W)) u_err_cntr (
    .clk_i (iCLK),
    .rst_i (iRESET),
    .inc_i (w_close && (w_close_stat != 4'd0)),
    .clr_i (iCNT_CLR),
    .cnt_o (oERR_CNT)
  );

  mtip_sat_cntr #(.CNT_W(CNT_W)) u_orphan_cntr (
    .clk_i (iCLK),
    .rst_i (iRESET),
    .inc_i (w_orphan),
    .clr_i (iCNT_CLR),
    .cnt_o (oORPHAN_CNT)
  );

  assign oHDR       = hdr_q;
  assign oHDR_VALID = hdr_valid_q;
  assign oPAY_DATA  = pay_data_q;
  assign oPAY_VALID = pay_valid_q;
  assign oPAY_SOP   = pay_sop_q;
  assign oPAY_EOP   = pay_eop_q;
  assign oFRM_DONE  = done_q;
  assign oFRM_LEN   = frm_len_q;
  assign oFRM_STAT  = frm_stat_q;

endmodule : mtip_hdr_extract
`default_nettype wire

// File: tb/tb_mtip_hdr_extract.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtip_hdr_extract
//  Description : Directed self-checking bench for mtip_hdr_extract.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mtip_hdr_extract;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  data = '0;
  logic         sop = 1'b0, eop = 1'b0, err = 1'b0, dval = 1'b0, cnt_clr = 1'b0;
  logic [191:0] hdr;
  logic         hdr_valid, pay_valid, pay_sop, pay_eop, frm_done;
  logic [31:0]  pay_data;
  logic [11:0]  frm_len;
  logic [3:0]   frm_stat;
  logic [31:0]  frm_cnt, err_cnt, orphan_cnt;

  mtip_hdr_extract dut (
    .iCLK        (clk),
    .iRESET      (rst),
    .iDATA       (data),
    .iSOP        (sop),
    .iEOP        (eop),
    .iERR        (err),
    .iDVAL       (dval),
    .iCNT_CLR    (cnt_clr),
    .oHDR        (hdr),
    .oHDR_VALID  (hdr_valid),
    .oPAY_DATA   (pay_data),
    .oPAY_VALID  (pay_valid),
    .oPAY_SOP    (pay_sop),
    .oPAY_EOP    (pay_eop),
    .oFRM_DONE   (frm_done),
    .oFRM_LEN    (frm_len),
    .oFRM_STAT   (frm_stat),
    .oFRM_CNT    (frm_cnt),
    .oERR_CNT    (err_cnt),
    .oORPHAN_CNT (orphan_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on every rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs every pulse/beat seen at the falling edge
  int           n_hdrv = 0, n_done = 0;
  int           hdrv_cyc = -1, done_cyc = -1;
  logic [191:0] last_hdr = '0;
  logic [33:0]  beats[$];      // {sop, eop, data}
  logic [15:0]  dones[$];      // {stat, len}
  always @(negedge clk) begin
    if (hdr_valid) begin
      n_hdrv   = n_hdrv + 1;
      hdrv_cyc = cyc;
      last_hdr = hdr;
    end
    if (pay_valid) beats.push_back({pay_sop, pay_eop, pay_data});
    if (frm_done) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
      dones.push_back({frm_stat, frm_len});
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int drv_cyc;
  task automatic word(input logic [31:0] d, input logic s, input logic e, input logic r);
    @(posedge clk); #1;
    data = d; sop = s; eop = e; err = r; dval = 1'b1;
    drv_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      data = '0; sop = 1'b0; eop = 1'b0; err = 1'b0; dval = 1'b0; cnt_clr = 1'b0;
    end
  endtask

  int b0, h0, d0, w6_cyc, eops;

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr", hdr, '0);
    chk("rst_hdrv", {191'd0, hdr_valid}, '0);
    chk("rst_pay", {158'd0, pay_valid, pay_sop, pay_eop, pay_data}, '0);
    chk("rst_done", {176'd0, frm_done, frm_len, frm_stat}, '0);
    chk("rst_cnts", {96'd0, frm_cnt, err_cnt, orphan_cnt}, '0);
    rst = 1'b0;
    idle(2);

    // ---------------- 10-word frame ----------------
    b0 = beats.size(); h0 = n_hdrv; d0 = dones.size();
    for (int i = 1; i <= 10; i++) begin
      word(32'(i), i == 1, i == 10, 1'b0);
      if (i == 6) w6_cyc = drv_cyc;
    end
    idle(3);
    chk("f10_hdrv_n", 192'(n_hdrv - h0), 192'd1);
    chk("f10_hdr", last_hdr, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});
    chk("f10_hdrv_cyc", 192'(hdrv_cyc), 192'(w6_cyc + 1));
    chk("f10_beats", 192'(beats.size() - b0), 192'd4);
    chk("f10_b0", 192'(beats[b0]),     {158'd0, 2'b10, 32'd7});
    chk("f10_b1", 192'(beats[b0 + 1]), {158'd0, 2'b00, 32'd8});
    chk("f10_b2", 192'(beats[b0 + 2]), {158'd0, 2'b00, 32'd9});
    chk("f10_b3", 192'(beats[b0 + 3]), {158'd0, 2'b01, 32'd10});
    chk("f10_done", 192'(dones.size() - d0), 192'd1);
    chk("f10_lenstat", 192'(dones[d0]), {176'd0, 4'b0000, 12'd10});
    chk("f10_frmcnt", 192'(frm_cnt), 192'd1);

    // ---------------- 6-word frame with ERR ----------------
    b0 = beats.size(); h0 = n_hdrv; d0 = dones.size();
    for (int i = 1; i <= 6; i++) word(32'h10 + 32'(i), i == 1, i == 6, i == 6);
    idle(3);
    chk("f6_hdrv_n", 192'(n_hdrv - h0), 192'd1);
    chk("f6_same_cyc", 192'(hdrv_cyc), 192'(done_cyc));
    chk("f6_hdr", last_hdr, {32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16});
    chk("f6_beats", 192'(beats.size() - b0), 192'd0);
    chk("f6_lenstat", 192'(dones[d0]), {176'd0, 4'b0001, 12'd6});
    chk("f6_errcnt", 192'(err_cnt), 192'd1);

    // ---------------- 3-word runt ----------------
    b0 = beats.size(); h0 = n_hdrv; d0 = dones.size();
    for (int i = 1; i <= 3; i++) word(32'h20 + 32'(i), i == 1, i == 3, 1'b0);
    idle(3);
    chk("runt_hdrv_n", 192'(n_hdrv - h0), 192'd0);
    chk("runt_hdr_hold", hdr, {32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16});
    chk("runt_lenstat", 192'(dones[d0]), {176'd0, 4'b0010, 12'd3});
    chk("runt_cnts", {128'd0, frm_cnt, err_cnt}, {128'd0, 32'd3, 32'd2});

    // ---------------- 540-word giant ----------------
    b0 = beats.size(); d0 = dones.size();
    for (int i = 1; i <= 540; i++) word(32'(i), i == 1, i == 540, 1'b0);
    idle(3);
    chk("giant_beats", 192'(beats.size() - b0), 192'd528);
    eops = 0;
    for (int i = b0; i < beats.size(); i++) if (beats[i][32]) eops++;
    chk("giant_eops", 192'(eops), 192'd0);
    chk("giant_first", 192'(beats[b0]), {158'd0, 2'b10, 32'd7});
    chk("giant_last", 192'(beats[beats.size() - 1]), {158'd0, 2'b00, 32'd534});
    chk("giant_lenstat", 192'(dones[d0]), {176'd0, 4'b1000, 12'd535});

    // ---------------- truncation: A (9 words, no EOP) then B ----------------
    b0 = beats.size(); d0 = dones.size();
    for (int i = 0; i <= 8; i++) word(32'h100 + 32'(i), i == 0, 1'b0, 1'b0);
    for (int i = 0; i <= 9; i++) word(32'h200 + 32'(i), i == 0, i == 9, 1'b0);
    idle(3);
    chk("trunc_dones", 192'(dones.size() - d0), 192'd2);
    chk("trunc_A", 192'(dones[d0]), {176'd0, 4'b0100, 12'd9});
    chk("trunc_beats", 192'(beats.size() - b0), 192'd8);
    chk("trunc_A_b2", 192'(beats[b0 + 2]), {158'd0, 2'b00, 32'h108});
    chk("trunc_forced", 192'(beats[b0 + 3]), {158'd0, 2'b01, 32'd0});
    chk("trunc_B_b0", 192'(beats[b0 + 4]), {158'd0, 2'b10, 32'h206});
    chk("trunc_B_hdr", last_hdr, {32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h205});
    chk("trunc_B", 192'(dones[d0 + 1]), {176'd0, 4'b0000, 12'd10});
    chk("trunc_cnts", {128'd0, frm_cnt, err_cnt}, {128'd0, 32'd6, 32'd4});

    // ---------------- orphans, then clear against a 1-word runt close ----------------
    b0 = beats.size(); h0 = n_hdrv; d0 = dones.size();
    for (int i = 0; i < 4; i++) word(32'hBAD0 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("orphan_cnt", 192'(orphan_cnt), 192'd4);
    chk("orphan_quiet", {128'd0, 32'(beats.size() - b0), 32'(n_hdrv - h0)}, '0);
    chk("orphan_nodone", 192'(dones.size() - d0), 192'd0);
    word(32'hC0DE, 1'b1, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    idle(3);
    chk("clr_cnts", {96'd0, frm_cnt, err_cnt, orphan_cnt}, '0);
    chk("sop_eop_runt", 192'(dones[d0]), {176'd0, 4'b0010, 12'd1});

    // ---------------- reset mid-frame ----------------
    d0 = dones.size(); h0 = n_hdrv;
    for (int i = 0; i < 4; i++) word(32'h300 + 32'(i), i == 0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    word(32'h399, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("rst_mid_nodone", 192'(dones.size() - d0), 192'd0);
    chk("rst_mid_cnts", {96'd0, frm_cnt, err_cnt, orphan_cnt}, {96'd0, 32'd0, 32'd0, 32'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mtip_hdr_extract
`default_nettype wire
